// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and buffer enable/flush outputs of the stall/flush controller
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] i_dec_rsrc1;
    logic [REG_W-1:0] i_dec_rsrc2;
    logic             i_dec_use1;
    logic             i_dec_use2;
    logic             i_ex_mem_read;
    logic [REG_W-1:0] i_ex_rdst;
    logic             i_ex_br_taken;
    logic             i_mem_wide;
    logic             o_pc_en;
    logic             o_fd_en;
    logic             o_fd_flush;
    logic             o_de_en;
    logic             o_de_flush;
    logic             o_em_en;
    logic             o_mw_en;
    logic             o_mw_flush;
    logic             o_mem_half;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_dec_rsrc1, i_dec_rsrc2, i_dec_use1, i_dec_use2,
               i_ex_mem_read, i_ex_rdst, i_ex_br_taken, i_mem_wide,
        input  o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush,
               o_em_en, o_mw_en, o_mw_flush, o_mem_half, o_stall_cnt
    );

    modport slave (
        input  i_dec_rsrc1, i_dec_rsrc2, i_dec_use1, i_dec_use2,
               i_ex_mem_read, i_ex_rdst, i_ex_br_taken, i_mem_wide,
        output o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush,
               o_em_en, o_mw_en, o_mw_flush, o_mem_half, o_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage stall/flush controller (load-use, taken branch, two-cycle wide memory op)
// Optional stall counter under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {
        RUN      = 1'b0,
        MEM_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic [REG_W-1:0] w_rd;
    logic             w_lu;
    logic             w_pc_en;
    logic             w_fd_en;
    logic             w_fd_flush;
    logic             w_de_en;
    logic             w_de_flush;
    logic             w_em_en;
    logic             w_mw_en;
    logic             w_mw_flush;
    logic             w_mem_half;

    assign w_rs1 = hz.i_dec_rsrc1;
    assign w_rs2 = hz.i_dec_rsrc2;
    assign w_rd  = hz.i_ex_rdst;
    // Register 0 is an ordinary register, so it takes part in the compare.
    assign w_lu  = hz.i_ex_mem_read &&
                   ((hz.i_dec_use1 && (w_rs1 == w_rd)) ||
                    (hz.i_dec_use2 && (w_rs2 == w_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = RUN;
        if (r_state == RUN && hz.i_mem_wide) begin
            w_next = MEM_HOLD;
        end
    end

    always_comb begin
        w_pc_en    = 1'b1;
        w_fd_en    = 1'b1;
        w_fd_flush = 1'b0;
        w_de_en    = 1'b1;
        w_de_flush = 1'b0;
        w_em_en    = 1'b1;
        w_mw_en    = 1'b1;
        w_mw_flush = 1'b0;
        w_mem_half = 1'b0;
        if (!rst) begin
            if (r_state == RUN && hz.i_mem_wide) begin
                // Freeze upstream; branch/lu are re-presented by the frozen stages next cycle.
                w_pc_en    = 1'b0;
                w_fd_en    = 1'b0;
                w_de_en    = 1'b0;
                w_em_en    = 1'b0;
                w_mw_flush = 1'b1;
            end else begin
                w_mem_half = (r_state == MEM_HOLD);
                if (hz.i_ex_br_taken) begin
                    w_fd_flush = 1'b1;
                    w_de_flush = 1'b1;
                end else if (w_lu) begin
                    w_pc_en    = 1'b0;
                    w_fd_en    = 1'b0;
                    w_de_flush = 1'b1;
                end
            end
        end
    end

    assign hz.o_pc_en    = w_pc_en;
    assign hz.o_fd_en    = w_fd_en;
    assign hz.o_fd_flush = w_fd_flush;
    assign hz.o_de_en    = w_de_en;
    assign hz.o_de_flush = w_de_flush;
    assign hz.o_em_en    = w_em_en;
    assign hz.o_mw_en    = w_mw_en;
    assign hz.o_mw_flush = w_mw_flush;
    assign hz.o_mem_half = w_mem_half;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hz.o_stall_cnt = rst ? {CNT_W{1'b0}} : r_stall_cnt;
`else
    logic [CNT_W-1:0] w_stall_zero;
    assign w_stall_zero   = '0;
    assign hz.o_stall_cnt = w_stall_zero;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    // {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush, mem_half}
    localparam logic [8:0] NORM    = 9'b1_1_0_1_0_1_1_0_0;
    localparam logic [8:0] BR      = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] LU      = 9'b0_0_0_1_1_1_1_0_0;
    localparam logic [8:0] W1      = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] HOLD    = 9'b1_1_0_1_0_1_1_0_1;
    localparam logic [8:0] HOLD_BR = 9'b1_1_1_1_1_1_1_0_1;
    localparam logic [8:0] HOLD_LU = 9'b0_0_0_1_1_1_1_0_1;

    typedef struct packed {
        logic       rst;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       u1;
        logic       u2;
        logic       mrd;
        logic [2:0] rd;
        logic       br;
        logic       wide;
        logic [8:0] exp;
    } row_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [8:0]  sb_exp[$];
    logic [15:0] sb_cnt[$];
    logic [15:0] cnt_model;

    pipe_hazard_ctrl_if #(.REG_W(3), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.REG_W(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic r, input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic u1, input logic u2, input logic mrd,
                                input logic [2:0] rd, input logic br, input logic wide,
                                input logic [8:0] e);
        row_t x;
        x.rst = r; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        x.mrd = mrd; x.rd = rd; x.br = br; x.wide = wide; x.exp = e;
        return x;
    endfunction

    function automatic logic [8:0] outs();
        return {bus.o_pc_en, bus.o_fd_en, bus.o_fd_flush, bus.o_de_en, bus.o_de_flush,
                bus.o_em_en, bus.o_mw_en, bus.o_mw_flush, bus.o_mem_half};
    endfunction

    // Applies one cycle of stimulus and records what the outputs must be in that cycle.
    task automatic drive_push(input row_t r);
        @(posedge clk);
        #1;
        rst                = r.rst;
        bus.i_dec_rsrc1    = r.rs1;
        bus.i_dec_rsrc2    = r.rs2;
        bus.i_dec_use1     = r.u1;
        bus.i_dec_use2     = r.u2;
        bus.i_ex_mem_read  = r.mrd;
        bus.i_ex_rdst      = r.rd;
        bus.i_ex_br_taken  = r.br;
        bus.i_mem_wide     = r.wide;
        sb_exp.push_back(r.exp);
`ifdef HAZARD_PERF_CNT_EN
        sb_cnt.push_back(r.rst ? 16'd0 : cnt_model);
        if (r.rst) cnt_model = 16'd0;
        else if (!r.exp[8] && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
`else
        sb_cnt.push_back(16'd0);
`endif
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [8:0] e;
        logic [15:0] c;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        rows.push_back(mk(1, 3, 3, 1, 1, 1, 3, 0, 1, NORM));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(negedge clk);
            e = sb_exp.pop_front();
            c = sb_cnt.pop_front();
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL reset[%0d] ctl got=%b want=%b", i, outs(), e); end
            checks++;
            if (bus.o_stall_cnt !== c) begin errors++; $display("FAIL reset[%0d] stall_cnt got=%0d want=%0d", i, bus.o_stall_cnt, c); end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [8:0] e;
        logic [15:0] c;
        rows.push_back(mk(0, 1, 3, 0, 1, 1, 3, 0, 0, LU));
        rows.push_back(mk(0, 1, 3, 0, 1, 0, 3, 0, 0, NORM));
        rows.push_back(mk(0, 1, 3, 0, 0, 1, 3, 0, 0, NORM));
        rows.push_back(mk(0, 0, 6, 1, 0, 1, 0, 0, 0, LU));
        rows.push_back(mk(0, 2, 4, 1, 1, 1, 7, 0, 0, NORM));
        rows.push_back(mk(0, 7, 7, 1, 1, 1, 7, 0, 0, LU));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(negedge clk);
            e = sb_exp.pop_front();
            c = sb_cnt.pop_front();
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL load_use[%0d] ctl got=%b want=%b", i, outs(), e); end
            checks++;
            if (bus.o_stall_cnt !== c) begin errors++; $display("FAIL load_use[%0d] stall_cnt got=%0d want=%0d", i, bus.o_stall_cnt, c); end
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [8:0] e;
        logic [15:0] c;
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, BR));
        rows.push_back(mk(0, 5, 2, 1, 0, 1, 5, 1, 0, BR));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(negedge clk);
            e = sb_exp.pop_front();
            c = sb_cnt.pop_front();
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL branch[%0d] ctl got=%b want=%b", i, outs(), e); end
            checks++;
            if (bus.o_stall_cnt !== c) begin errors++; $display("FAIL branch[%0d] stall_cnt got=%0d want=%0d", i, bus.o_stall_cnt, c); end
        end
    endtask

    task automatic test_back_to_back_wide();
        row_t rows[$];
        logic [8:0] e;
        logic [15:0] c;
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, W1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, HOLD));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, W1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, HOLD));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, W1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, HOLD));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(negedge clk);
            e = sb_exp.pop_front();
            c = sb_cnt.pop_front();
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL wide[%0d] ctl got=%b want=%b", i, outs(), e); end
            checks++;
            if (bus.o_stall_cnt !== c) begin errors++; $display("FAIL wide[%0d] stall_cnt got=%0d want=%0d", i, bus.o_stall_cnt, c); end
        end
    endtask

    task automatic test_wide_hazard();
        row_t rows[$];
        logic [8:0] e;
        logic [15:0] c;
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, W1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, HOLD_BR));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        rows.push_back(mk(0, 4, 0, 1, 0, 1, 4, 0, 1, W1));
        rows.push_back(mk(0, 4, 0, 1, 0, 1, 4, 0, 1, HOLD_LU));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(negedge clk);
            e = sb_exp.pop_front();
            c = sb_cnt.pop_front();
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL wide_hazard[%0d] ctl got=%b want=%b", i, outs(), e); end
            checks++;
            if (bus.o_stall_cnt !== c) begin errors++; $display("FAIL wide_hazard[%0d] stall_cnt got=%0d want=%0d", i, bus.o_stall_cnt, c); end
        end
    endtask

    task automatic test_reset_mid_hold_and_count();
        row_t rows[$];
        logic [8:0] e;
        logic [15:0] c;
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, W1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, NORM));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        rows.push_back(mk(0, 5, 0, 1, 0, 1, 5, 0, 0, LU));
        rows.push_back(mk(0, 0, 2, 0, 1, 1, 2, 0, 0, LU));
        rows.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0, 0, LU));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, W1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, HOLD));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(negedge clk);
            e = sb_exp.pop_front();
            c = sb_cnt.pop_front();
            checks++;
            if (outs() !== e) begin errors++; $display("FAIL rst_hold_cnt[%0d] ctl got=%b want=%b", i, outs(), e); end
            checks++;
            if (bus.o_stall_cnt !== c) begin errors++; $display("FAIL rst_hold_cnt[%0d] stall_cnt got=%0d want=%0d", i, bus.o_stall_cnt, c); end
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (bus.o_stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_total got=%0d want=4", bus.o_stall_cnt); end
`endif
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        cnt_model         = 16'd0;
        rst               = 1'b1;
        bus.i_dec_rsrc1   = '0;
        bus.i_dec_rsrc2   = '0;
        bus.i_dec_use1    = 1'b0;
        bus.i_dec_use2    = 1'b0;
        bus.i_ex_mem_read = 1'b0;
        bus.i_ex_rdst     = '0;
        bus.i_ex_br_taken = 1'b0;
        bus.i_mem_wide    = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back_wide();
        test_wide_hazard();
        test_reset_mid_hold_and_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage core. Drives the enable and flush inputs of the fetch/decode, decode/ALU, ALU/memory and memory/writeback buffers, plus the PC register enable. It resolves three hazard types:
- load-use data hazards;
- taken branches resolved in the ALU stage;
- two-cycle 32-bit memory accesses (PC push/pop for CALL/RET/INT).

Parameters:
REG_W, 3, register index width (8 GPRs)
CNT_W, 16, width of stall counter (optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
dec_rsrc1  in  REG_W  source reg 1 of instruction in decode
dec_rsrc2  in  REG_W  source reg 2 of instruction in decode
dec_use1  in  1  decode instruction reads rsrc1
dec_use2  in  1  decode instruction reads rsrc2
ex_mem_read  in  1  instruction in ALU stage is a load (o_Mem read)
ex_rdst  in  REG_W  destination of ALU-stage instruction
ex_br_taken  in  1  ALU stage resolved a taken branch/jump
mem_wide  in  1  memory-stage op is a 32-bit access
pc_en  out  1  PC register update enable
fd_en  out  1  fetch/decode buffer enable
fd_flush  out  1  fetch/decode buffer flush (loads bubble)
de_en  out  1  decode/ALU buffer enable
de_flush  out  1  decode/ALU buffer flush
em_en  out  1  ALU/memory buffer enable
mw_en  out  1  memory/writeback buffer enable
mw_flush  out  1  memory/writeback buffer flush
mem_half  out  1  0 = first (low) half of wide access, 1 = second (high) half
stall_cnt  out  CNT_W  stall-cycle count (0 when feature absent)

Behaviour:
- Buffers treat flush as a synchronous clear that overrides en.
- Outputs are a Mealy decode of the registered state plus the current inputs. No added latency: hazards act in the same cycle they are detected.
- FSM states: RUN, MEM_HOLD.
- Reset:
  - state = RUN.
  - While rst=1: all en = 1, all flush = 0, mem_half = 0, stall_cnt = 0.
  - rst mid-hold abandons the wide access and returns to RUN next cycle.
- Definitions:
  - Load-use hit (lu): ex_mem_read AND ((dec_use1 AND dec_rsrc1==ex_rdst) OR (dec_use2 AND dec_rsrc2==ex_rdst)).
- RUN, evaluated in priority order:
  1. mem_wide=1 (wide-first):
     - pc_en = fd_en = de_en = em_en = 0; mw_flush = 1; mem_half = 0.
     - Next state MEM_HOLD.
     - ex_br_taken and lu are ignored this cycle. The frozen stages re-present them next cycle.
  2. ex_br_taken=1:
     - pc_en = 1 (target loaded); fd_flush = 1; de_flush = 1; others enabled.
     - lu is ignored (the decode instruction is squashed anyway).
  3. lu=1:
     - pc_en = fd_en = 0; de_flush = 1 (bubble into ALU); em_en = mw_en = 1.
     - Remains RUN; re-evaluated next cycle.
  4. Otherwise: all en = 1, all flush = 0.
- MEM_HOLD (second half):
  - mem_half = 1; all en = 1; mw_flush = 0, so the completed wide op advances.
  - Branch/lu rules (items 2 and 3 above) apply in this cycle as in RUN.
  - Next state is RUN unconditionally. mem_wide is ignored in MEM_HOLD: the next wide op is a new instruction, seen in RUN the following cycle.
- Back-to-back wide ops produce a strict RUN, MEM_HOLD, RUN, MEM_HOLD sequence with one bubble each.
- Back-to-back loads with dependents produce one bubble per dependent instruction.
- Register index 0 is a real register; no zero-register exemption.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments by 1 on every cycle in which pc_en=0 (lu or wide-first), saturates at all-ones, and is cleared by rst.
- Undefined: stall_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release with no hazards -> all en=1, all flush=0, mem_half=0, stall_cnt=0.
- Load-use: ex_mem_read=1, ex_rdst=3, dec_rsrc2=3, dec_use2=1 -> pc_en=0, fd_en=0, de_flush=1 for exactly 1 cycle. Same with dec_use2=0 -> no stall.
- Branch: ex_br_taken=1 in RUN -> fd_flush=1, de_flush=1, pc_en=1. Branch plus lu in the same cycle -> no stall, flushes only.
- Wide access: mem_wide=1 for 2 cycles -> cycle 1: upstream en=0, mw_flush=1, mem_half=0; cycle 2: mem_half=1, all en=1; cycle 3 back in RUN. A second mem_wide pulse repeats the sequence.
- Wide plus branch: mem_wide=1 with ex_br_taken=1 -> cycle 1 freezes with no flush; cycle 2 asserts fd_flush and de_flush.
- Reset mid-hold, and counter (HAZARD_PERF_CNT_EN): rst=1 in MEM_HOLD -> RUN with mem_half=0 next cycle. With the macro defined, 3 lu stalls plus 1 wide op -> stall_cnt=4.
